// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Combinational helpers only; no state lives here.
package uart_arb_pkg;

  localparam int MAX_REQ       = 8;
  localparam int BYTE_W        = 8;
  localparam int ACK_GUARD_DEF = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOCKED    = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

  // Round-robin successor of a requester index, wrapping n-1 back to 0.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: one-hot first set request scanning upward from ptr with wrap.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a pick is consumed.
module rr_picker #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic          any
);

  // Walk offsets from farthest to nearest so the slot at ptr overrides last.
  always_comb begin
    pick = '0;
    for (int k = N - 1; k >= 0; k--) begin
      for (int j = 0; j < N; j++) begin
        if (req[j] && (j == (int'(ptr) + k) % N)) begin
          pick    = '0;
          pick[j] = 1'b1;
        end
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ byte streams; grant is held for a whole message.
// Latency: grant 1 cycle after a request in IDLE; tx_start 1 cycle after a handshake.
// Backpressure: owner ready only while LOCKED and uart_tx idle; non-owners are held off.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ACK_GUARD      = ACK_GUARD_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      tx_start,
  output logic [BYTE_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic                      timeout_pulse
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = $clog2(ACK_GUARD + 1);

  localparam logic [SW-1:0] STALL_LIMIT = SW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW-1:0] ACK_LIMIT   = AW'(ACK_GUARD - 1);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_num_req_check
    $error("uart_tx_arbiter: NUM_REQ must be within 2..8");
  end

  arb_state_t        state;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     owner_idx;
  logic [SW-1:0]     stall_cnt;
  logic [AW-1:0]     ack_cnt;
  logic              last_flag;

  logic [NUM_REQ-1:0] pick;
  logic               any;
  logic [PW-1:0]      pick_idx;
  logic [PW-1:0]      next_ptr;

  logic               owner_valid;
  logic               owner_last;
  logic [BYTE_W-1:0]  owner_byte;
  logic               can_take;
  logic               handshake;
  logic               frame_done;

  rr_picker #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_picker (
    .req  (req_valid),
    .ptr  (rr_ptr),
    .pick (pick),
    .any  (any)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) pick_idx = PW'(i);
    end
  end

  // grant is one-hot (or zero), so masking with it selects the owner's lane.
  always_comb begin
    owner_valid = |(req_valid & grant);
    owner_last  = |(req_last & grant);
    owner_byte  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) owner_byte = owner_byte | req_data[i*BYTE_W +: BYTE_W];
    end
  end

  assign next_ptr  = PW'(wrap_inc(int'(owner_idx), NUM_REQ));
  assign can_take  = (state == LOCKED) && !tx_busy;
  assign req_ready = can_take ? (req_valid & grant) : '0;
  assign handshake = can_take && owner_valid;

  // A frame also counts as finished when uart_tx never acknowledged tx_start.
  assign frame_done = !tx_busy &&
                      ((state == WAIT_DONE) ||
                       ((state == WAIT_ACK) && (ack_cnt >= ACK_LIMIT)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      grant         <= '0;
      owner_idx     <= '0;
      rr_ptr        <= '0;
      stall_cnt     <= '0;
      ack_cnt       <= '0;
      last_flag     <= 1'b0;
      tx_start      <= 1'b0;
      tx_data       <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      tx_start      <= 1'b0;
      timeout_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (any && !tx_busy) begin
            grant     <= pick;
            owner_idx <= pick_idx;
            stall_cnt <= '0;
            state     <= LOCKED;
          end
        end

        LOCKED: begin
          if (handshake) begin
            tx_data   <= owner_byte;
            tx_start  <= 1'b1;
            last_flag <= owner_last;
            stall_cnt <= '0;
            ack_cnt   <= '0;
            state     <= WAIT_ACK;
          end else if (!owner_valid) begin
            if (stall_cnt >= STALL_LIMIT) begin
              timeout_pulse <= 1'b1;
              grant         <= '0;
              rr_ptr        <= next_ptr;
              stall_cnt     <= '0;
              state         <= IDLE;
            end else begin
              stall_cnt <= stall_cnt + 1'b1;
            end
          end
        end

        WAIT_ACK, WAIT_DONE: begin
          if ((state == WAIT_ACK) && tx_busy) begin
            state <= WAIT_DONE;
          end else if (frame_done) begin
            if (last_flag) begin
              grant  <= '0;
              rr_ptr <= next_ptr;
              state  <= IDLE;
            end else begin
              state <= LOCKED;
            end
          end else if (state == WAIT_ACK) begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter and rr_picker with a simple uart_tx busy model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic           clk       = 1'b0;
  logic           rst       = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_last  = '0;
  logic [8*N-1:0] req_data  = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic           timeout_pulse;

  uart_tx_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (TO),
    .ACK_GUARD      (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .grant         (grant),
    .tx_start      (tx_start),
    .tx_data       (tx_data),
    .tx_busy       (tx_busy),
    .timeout_pulse (timeout_pulse)
  );

  logic [3:0] pk_req;
  logic [1:0] pk_ptr;
  logic [3:0] pk_pick;
  logic       pk_any;

  rr_picker #(.N(4), .PW(2)) u_pk (
    .req  (pk_req),
    .ptr  (pk_ptr),
    .pick (pk_pick),
    .any  (pk_any)
  );

  always #5 clk = ~clk;

  int n_asrt = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Requester sources: per-requester byte queues, popped on accepted handshakes.
  logic [8:0]   mem [N][32];
  int           wr [N];
  int           rd [N];
  logic [N-1:0] hs = '0;

  always @(posedge clk) hs <= req_ready;

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (hs[i] === 1'b1) rd[i] = rd[i] + 1;
      req_valid[i] = (rd[i] != wr[i]);
      {req_last[i], req_data[8*i +: 8]} = mem[i][rd[i] % 32];
    end
  end

  task automatic push(input int r, input logic [7:0] b, input logic l);
    mem[r][wr[r] % 32] = {l, b};
    wr[r] = wr[r] + 1;
  endtask

  // uart_tx model: busy for 10 cycles after each start unless acknowledgement is suppressed.
  int busy_cnt = 0;
  bit no_busy  = 1'b0;
  always @(posedge clk) begin
    if (tx_start === 1'b1 && !no_busy) busy_cnt <= 10;
    else if (busy_cnt > 0)             busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  // Event log sampled at the clock edge (values of the cycle that is ending).
  int           cyc = 0, n_log = 0, n_g = 0, n_to = 0, bad_ready = 0;
  int           fall_cyc = 0, gfall_cyc = 0, g_cyc = 0, to_cyc = 0;
  logic         prev_busy = 1'b0, g_busy = 1'b0;
  logic [N-1:0] prev_gnt = '0, to_gnt = '0;
  logic [7:0]   log_dat [64];
  logic [N-1:0] log_gnt [64];
  int           log_cyc [64];
  logic [N-1:0] g_log   [64];

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    prev_busy <= tx_busy;
    prev_gnt  <= grant;
    if (tx_start === 1'b1 && n_log < 64) begin
      log_dat[n_log] <= tx_data;
      log_gnt[n_log] <= grant;
      log_cyc[n_log] <= cyc;
      n_log          <= n_log + 1;
    end
    if (!tx_busy && prev_busy) fall_cyc <= cyc;
    if (grant == '0 && prev_gnt != '0) gfall_cyc <= cyc;
    if (grant != '0 && prev_gnt == '0 && n_g < 64) begin
      g_log[n_g] <= grant;
      g_cyc      <= cyc;
      g_busy     <= prev_busy;
      n_g        <= n_g + 1;
    end
    if (timeout_pulse === 1'b1) begin
      to_cyc <= cyc;
      to_gnt <= grant;
      n_to   <= n_to + 1;
    end
    if ((req_ready & ~grant) != '0) bad_ready <= bad_ready + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_grant(input string tag, input logic [N-1:0] exp, input int budget);
    int k = 0;
    while (grant !== exp && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(grant), 32'(exp));
  endtask

  task automatic wait_logs(input string tag, input int target, input int budget);
    int k = 0;
    while (n_log < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(n_log >= target), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_grant"},   32'(grant),         32'd0);
    chk({tag, "_start"},   32'(tx_start),      32'd0);
    chk({tag, "_data"},    32'(tx_data),       32'd0);
    chk({tag, "_timeout"}, 32'(timeout_pulse), 32'd0);
    chk({tag, "_ready"},   32'(req_ready),     32'd0);
    chk({tag, "_rr_ptr"},  32'(dut.rr_ptr),    32'd0);
  endtask

  logic [3:0] pk_req_t  [8] = '{4'b0000, 4'b1010, 4'b1010, 4'b1010, 4'b0101, 4'b0101, 4'b1111, 4'b0001};
  logic [1:0] pk_ptr_t  [8] = '{2'd0,    2'd0,    2'd2,    2'd3,    2'd3,    2'd1,    2'd2,    2'd1};
  logic [4:0] pk_exp_t  [8] = '{5'b00000, 5'b10010, 5'b11000, 5'b11000, 5'b10001, 5'b10100, 5'b10100, 5'b10001};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, gb, tb0;
    int k;

    // rr_picker alone
    for (int v = 0; v < 8; v++) begin
      pk_req = pk_req_t[v];
      pk_ptr = pk_ptr_t[v];
      #1;
      chk($sformatf("picker_v%0d", v), 32'({pk_any, pk_pick}), 32'(pk_exp_t[v]));
    end

    tick(3);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // 1: single three-byte message from requester 1
    b = n_log; gb = n_g;
    push(1, 8'h48, 1'b0); push(1, 8'h49, 1'b0); push(1, 8'h0A, 1'b1);
    wait_grant("t1_grant", 4'b0010, 20);
    wait_logs("t1_bytes_seen", b + 3, 80);
    wait_grant("t1_release", 4'b0000, 30);
    tick(2);
    chk("t1_bytes", {8'h00, log_dat[b], log_dat[b+1], log_dat[b+2]}, 32'h0048490A);
    chk("t1_grants", 32'({log_gnt[b], log_gnt[b+1], log_gnt[b+2]}), 32'h222);
    chk("t1_one_grant", 32'(n_g - gb), 32'd1);
    chk("t1_release_lat", 32'(gfall_cyc - fall_cyc), 32'd1);

    // 2: requesters 0 and 2 contend right after reset
    rst = 1'b1; tick(1); rst = 1'b0;
    b = n_log; gb = n_g;
    push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b1);
    push(2, 8'hC0, 1'b0); push(2, 8'hC1, 1'b1);
    wait_logs("t2_bytes_seen", b + 4, 120);
    wait_grant("t2_release", 4'b0000, 30);
    tick(2);
    chk("t2_bytes", {log_dat[b], log_dat[b+1], log_dat[b+2], log_dat[b+3]}, 32'hA0A1C0C1);
    chk("t2_grants", 32'({log_gnt[b], log_gnt[b+1], log_gnt[b+2], log_gnt[b+3]}), 32'h1144);
    chk("t2_two_grants", 32'(n_g - gb), 32'd2);
    chk("t2_rr_ptr", 32'(dut.rr_ptr), 32'd3);

    // 3: all four send two single-byte messages each
    rst = 1'b1; tick(1); rst = 1'b0;
    b = n_log; gb = n_g;
    for (int r = 0; r < N; r++) push(r, 8'(48 + r), 1'b1);
    for (int r = 0; r < N; r++) push(r, 8'(64 + r), 1'b1);
    wait_logs("t3_bytes_seen", b + 8, 220);
    wait_grant("t3_release", 4'b0000, 30);
    tick(2);
    chk("t3_order_a", 32'({g_log[gb], g_log[gb+1], g_log[gb+2], g_log[gb+3]}), 32'h1248);
    chk("t3_order_b", 32'({g_log[gb+4], g_log[gb+5], g_log[gb+6], g_log[gb+7]}), 32'h1248);
    chk("t3_bytes_a", {log_dat[b], log_dat[b+1], log_dat[b+2], log_dat[b+3]}, 32'h30313233);
    chk("t3_bytes_b", {log_dat[b+4], log_dat[b+5], log_dat[b+6], log_dat[b+7]}, 32'h40414243);

    // 4: requester 3 stalls mid-message, requester 0 waits
    b = n_log; tb0 = n_to;
    push(3, 8'h33, 1'b0);
    wait_grant("t4_grant3", 4'b1000, 20);
    push(0, 8'h55, 1'b1);
    k = 0;
    while (n_to == tb0 && k < 80) begin
      tick(1);
      k++;
    end
    chk("t4_timeout_seen", 32'(n_to - tb0), 32'd1);
    chk("t4_timeout_lat", 32'(to_cyc - fall_cyc), 32'd17);
    chk("t4_timeout_grant", 32'(to_gnt), 32'd0);
    wait_grant("t4_next_grant", 4'b0001, 5);
    wait_logs("t4_bytes_seen", b + 2, 40);
    chk("t4_regrant_lat", 32'(g_cyc - to_cyc), 32'd1);
    chk("t4_bytes", 32'({log_dat[b], log_dat[b+1]}), 32'h3355);
    chk("t4_owner0", 32'(log_gnt[b+1]), 32'd1);
    wait_grant("t4_release", 4'b0000, 30);
    tick(2);
    chk("t4_single_pulse", 32'(n_to - tb0), 32'd1);

    // 5: uart_tx never acknowledges
    no_busy = 1'b1;
    b = n_log;
    push(2, 8'h11, 1'b0); push(2, 8'h22, 1'b1);
    wait_logs("t5_bytes_seen", b + 2, 40);
    wait_grant("t5_release", 4'b0000, 20);
    tick(2);
    chk("t5_bytes", 32'({log_dat[b], log_dat[b+1]}), 32'h1122);
    chk("t5_start_gap", 32'(log_cyc[b+1] - log_cyc[b]), 32'd5);
    chk("t5_release_lat", 32'(gfall_cyc - log_cyc[b+1]), 32'd4);
    no_busy = 1'b0;

    // 6: reset while requester 1's second byte is on the line
    b = n_log;
    push(1, 8'hB0, 1'b0); push(1, 8'hB1, 1'b0); push(1, 8'hB2, 1'b1);
    wait_grant("t6_grant1", 4'b0010, 20);
    push(0, 8'hD0, 1'b1);
    wait_logs("t6_two_bytes", b + 2, 60);
    tick(3);
    chk("t6_in_frame", 32'(tx_busy), 32'd1);
    rst = 1'b1; tick(1);
    chk_reset_outputs("t6_reset");
    rst = 1'b0;
    tick(2);
    chk("t6_hold_while_busy", 32'(grant), 32'd0);
    gb = n_g;
    wait_grant("t6_grant0", 4'b0001, 20);
    tick(1);
    chk("t6_grant_after_fall", 32'(g_cyc - fall_cyc), 32'd1);
    chk("t6_grant_busy_low", 32'(g_busy), 32'd0);
    wait_logs("t6_rest_seen", b + 4, 80);
    wait_grant("t6_release", 4'b0000, 30);
    tick(2);
    chk("t6_bytes", {log_dat[b], log_dat[b+1], log_dat[b+2], log_dat[b+3]}, 32'hB0B1D0B2);
    chk("t6_owners", 32'({log_gnt[b+2], log_gnt[b+3]}), 32'h12);

    chk("no_foreign_ready", 32'(bad_ready), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between NUM_REQ byte-stream requesters, e.g. button-triggered message generators, a debug logger and the badge-to-badge link.
- Each requester presents bytes with a valid/ready handshake and marks the final byte of a message with last.
- The arbiter grants round-robin and holds the grant until that message completes, so messages never interleave on the line.
- It feeds the uart_tx start/data/busy interface and sits between the requesters and uart_tx in top.

Parameters:
- NUM_REQ, 4: number of requesters, legal range 2..8.
- TIMEOUT_CYCLES, 1024: idle cycles a granted owner may stall (valid low) before its lock is revoked.
- ACK_GUARD, 4: maximum cycles to wait for tx_busy to rise after tx_start.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  flattened bytes; requester i uses bits [8i+7:8i].
- req_last  in  NUM_REQ  the offered byte is the last of its message.
- req_ready  out  NUM_REQ  byte accepted this cycle (combinational).
- grant  out  NUM_REQ  one-hot current owner, or 0 when none.
- tx_start  out  1  one-cycle pulse to uart_tx.
- tx_data  out  8  byte for uart_tx; held stable from tx_start until tx_busy falls.
- tx_busy  in  1  uart_tx is shifting a frame.
- timeout_pulse  out  1  one-cycle pulse when a lock is revoked.

Behaviour:
- Reset values: state IDLE, grant=0, tx_start=0, tx_data=0, timeout_pulse=0, rr_ptr=0, stall counter=0. Reset wins over every other event, including mid-frame. The arbiter does not abort uart_tx; after reset it waits in IDLE, and nothing is granted while tx_busy=1.
- States: IDLE, LOCKED, WAIT_ACK, WAIT_DONE.
- IDLE:
  - When |req_valid and !tx_busy, pick the first requester with valid set, scanning from index rr_ptr upward with wrap (rr_ptr itself has highest priority).
  - Next cycle: grant=onehot(pick), state LOCKED. Arbitration latency is 1 cycle.
- LOCKED:
  - req_ready[owner] = req_valid[owner] & !tx_busy. All other req_ready bits are 0 in every state.
  - On handshake: register tx_data=byte, pulse tx_start for 1 cycle, latch last_flag=req_last[owner], go to WAIT_ACK.
  - Stall counter increments each LOCKED cycle with req_valid[owner]=0 and clears on handshake.
  - When the counter reaches TIMEOUT_CYCLES-1 with valid still low: timeout_pulse=1, grant=0, rr_ptr=owner+1 (mod NUM_REQ), state IDLE.
- WAIT_ACK:
  - Go to WAIT_DONE on tx_busy=1.
  - If tx_busy has not risen after ACK_GUARD cycles, treat the frame as complete and proceed as if WAIT_DONE saw tx_busy=0.
- WAIT_DONE:
  - On tx_busy=0: if last_flag, set grant=0, rr_ptr=owner+1 mod NUM_REQ, state IDLE.
  - Otherwise return to LOCKED.
- Throughput: at most one byte per uart_tx frame; back-to-back bytes within a message need no re-arbitration.
- Simultaneous events: a requester dropping valid while it is not owner has no effect. req_valid and req_last are only sampled for the owner. Non-owner valid is held off and must stay asserted (AXI-style: data stable while valid and not ready).
- A single-byte message (last on the first byte) is legal.
- The IDLE and release path costs 1 dead cycle between messages.
- rr_ptr has width $clog2(NUM_REQ); the increment wraps NUM_REQ-1 to 0. The stall counter has width $clog2(TIMEOUT_CYCLES+1) and saturates, never wrapping.

Decomposition:
- Package uart_arb_pkg holds:
  - the state enum (IDLE, LOCKED, WAIT_ACK, WAIT_DONE);
  - the ACK_GUARD default;
  - the MAX_REQ=8 constant and the byte width constant.
- Sub-module rr_picker is purely combinational:
  - inputs: req vector and ptr;
  - outputs: one-hot pick and any.
  - Unit-test it separately.

Test Plan:
1. Single message: requester 1 sends 0x48,0x49,0x0A (last on 0x0A), uart_tx model with busy high 10 cycles. Expect three tx_start pulses with tx_data 0x48,0x49,0x0A in order, grant=0010 throughout, and grant=0 one cycle after the final busy fall.
2. Contention: requesters 0 and 2 raise valid in the same cycle after reset, each with a 2-byte message. Expect requester 0's two bytes then requester 2's two bytes, no interleave, and rr_ptr=3 at the end.
3. Round-robin fairness: all four requesters continuously send 1-byte messages for 8 grants. Expect grant order 0,1,2,3,0,1,2,3.
4. Timeout: with TIMEOUT_CYCLES=16, requester 3 is granted, sends one non-last byte, then drops valid. Expect timeout_pulse 16 cycles after return to LOCKED, grant=0, and a pending requester 0 granted next.
5. Missing busy: the uart_tx model never raises tx_busy. Expect WAIT_ACK exits after 4 cycles and the next byte's tx_start follows; no deadlock.
6. Reset mid-message: assert rst for 1 cycle during WAIT_DONE of requester 1's second byte. Expect all outputs at reset values next cycle, and requester 0 granted first afterwards, only once tx_busy=0.
